// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake, and feeds the IF/ID register with stall, squash and a one-entry hold buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_offset,
  input  logic [31:0] i_branch_base,
  input  logic        i_jump,
  input  logic [25:0] i_jump_index,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc4,
  output logic        o_if_id_valid
);

  localparam logic [0:0] S_REQ  = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // Low bits are forced to zero so the PC can never leave word alignment.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic [31:0] redirect_tgt_q, redirect_tgt_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] target;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_tgt = i_branch_base + {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
  assign jump_tgt   = {i_branch_base[31:28], i_jump_index, 2'b00};
  assign target     = i_jump ? jump_tgt : branch_tgt;
  assign redirect   = (i_branch_taken | i_jump) & ~i_stall;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    pc_d           = pc_q;
    squash_d       = squash_q;
    redirect_tgt_d = redirect_tgt_q;
    hold_buf_d     = hold_buf_q;
    hold_pc4_d     = hold_pc4_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_pc4_d    = if_id_pc4_q;
    if_id_valid_d  = if_id_valid_q;

    case (state_q)
      S_REQ: begin
        if (i_imem_ack) begin
          if (squash_q) begin
            // Word belongs to the abandoned path; a newer redirect wins over the saved one.
            pc_d     = redirect ? target : redirect_tgt_q;
            squash_d = 1'b0;
            if (!i_stall) if_id_valid_d = 1'b0;
          end else if (redirect) begin
            pc_d          = target;
            if_id_valid_d = 1'b0;
          end else if (i_stall) begin
            hold_buf_d = i_imem_rdata;
            hold_pc4_d = pc_plus4;
            pc_d       = pc_plus4;
            state_d    = S_HOLD;
          end else begin
            if_id_instr_d = i_imem_rdata;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
          end
        end else begin
          if (redirect) begin
            squash_d       = 1'b1;
            redirect_tgt_d = target;
          end
          if (!i_stall) if_id_valid_d = 1'b0;
        end
      end
      default: begin
        if (!i_stall) begin
          state_d = S_REQ;
          if (redirect) begin
            if_id_valid_d = 1'b0;
            pc_d          = target;
          end else begin
            if_id_instr_d = hold_buf_q;
            if_id_pc4_d   = hold_pc4_q;
            if_id_valid_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC_ALIGNED;
      squash_q      <= 1'b0;
      if_id_instr_q <= 32'd0;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // NOTE: payload registers carry no reset; they are only read once state/squash marks them live.
  always_ff @(posedge i_clk) begin
    redirect_tgt_q <= redirect_tgt_d;
    hold_buf_q     <= hold_buf_d;
    hold_pc4_q     <= hold_pc4_d;
  end

  assign o_imem_req    = i_rst_n & (state_q == S_REQ);
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_if_id_instr = if_id_instr_q;
  assign o_if_id_pc4   = if_id_pc4_q;
  assign o_if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed redirect table, multi-cycle
// corner sequences, then random stimulus against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [15:0] off;
  logic [31:0] base;
  logic        jmp;
  logic [25:0] idx;
  logic        ack;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  // Second instance exercising address wrap from a high reset PC.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;

  assign rdata   = addr ^ PAT;
  assign w_rdata = w_addr ^ PAT;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_branch_taken(br), .i_branch_offset(off), .i_branch_base(base),
    .i_jump(jmp), .i_jump_index(idx),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_pc(pc), .o_if_id_instr(ifid_instr), .o_if_id_pc4(ifid_pc4), .o_if_id_valid(ifid_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0),
    .i_branch_taken(1'b0), .i_branch_offset(16'h0), .i_branch_base(32'h0),
    .i_jump(1'b0), .i_jump_index(26'h0),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_ack(1'b1), .i_imem_rdata(w_rdata),
    .o_pc(w_pc), .o_if_id_instr(w_instr), .o_if_id_pc4(w_pc4), .o_if_id_valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [63:0] m_held[$];   // fetched word parked while decode is stalled
  logic [31:0] m_pend[$];   // redirect waiting for the in-flight read to return

  function automatic void model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
    m_held.delete();
    m_pend.delete();
  endfunction

  function automatic logic model_req();
    return m_held.size() == 0;
  endfunction

  function automatic logic [31:0] calc_target(input logic b_jmp, input logic [15:0] b_off,
                                              input logic [31:0] b_base, input logic [25:0] b_idx);
    int so;
    if (b_jmp) return {b_base[31:28], b_idx, 2'b00};
    so = $signed(b_off);
    return b_base + 32'(so * 4);
  endfunction

  function automatic void model_step(input logic s, input logic b, input logic j,
                                     input logic [15:0] o, input logic [31:0] bs,
                                     input logic [25:0] ix, input logic a);
    logic        redir;
    logic [31:0] tgt;
    redir = (b || j) && !s;
    tgt   = calc_target(j, o, bs, ix);
    if (m_held.size() != 0) begin
      if (!s) begin
        if (redir) begin
          m_held.delete();
          m_valid = 1'b0;
          m_pc    = tgt;
        end else begin
          {m_instr, m_pc4} = m_held.pop_front();
          m_valid = 1'b1;
        end
      end
    end else if (!a) begin
      if (redir) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
      if (!s) m_valid = 1'b0;
    end else if (m_pend.size() != 0 || redir) begin
      m_pc = redir ? tgt : m_pend[0];
      m_pend.delete();
      if (!s) m_valid = 1'b0;
    end else if (s) begin
      m_held.push_back({m_pc ^ PAT, m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end else begin
      m_instr = m_pc ^ PAT;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endfunction

  task automatic check_model();
    check("pc", pc, m_pc);
    check("req", 32'(req), 32'(model_req()));
    check("addr", addr, m_pc);
    check("valid", 32'(ifid_valid), 32'(m_valid));
    check("instr", ifid_instr, m_instr);
    check("pc4", ifid_pc4, m_pc4);
  endtask

  task automatic step(input logic s, input logic b, input logic j, input logic [15:0] o,
                      input logic [31:0] bs, input logic [25:0] ix, input logic a);
    stall = s; br = b; jmp = j; off = o; base = bs; idx = ix; ack = a;
    model_step(s, b, j, o, bs, ix, a);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic fetch(input logic a);
    step(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 26'h0, a);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; jmp = 1'b0; ack = 1'b0;
    #1;
    check("req_in_reset", 32'(req), 32'h0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_req", 32'(req), 32'h0);
      check("rst_valid", 32'(ifid_valid), 32'h0);
      check("rst_instr", ifid_instr, 32'h0);
      check("rst_pc4", ifid_pc4, 32'h0);
    end
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        br;
    logic        jmp;
    logic [15:0] off;
    logic [31:0] base;
    logic [25:0] idx;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[6];

  initial begin
    logic [31:0] p;
    vecs[0] = '{1'b1, 1'b0, 16'hFFFC, 32'h0000_0010, 26'h0,         32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0003, 32'h0000_0010, 26'h0,         32'h0000_001C};
    vecs[2] = '{1'b1, 1'b1, 16'h0005, 32'h8000_0010, 26'h010_0000,  32'h8040_0000};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 32'h7000_0004, 26'h3FF_FFFF,  32'h7FFF_FFFC};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 32'h0010_0000, 26'h0,         32'h000E_0000};
    vecs[5] = '{1'b1, 1'b0, 16'h7FFF, 32'hFFFF_FFF0, 26'h0,         32'h0001_FFEC};

    off = 16'h0; base = 32'h0; idx = 26'h0;
    apply_reset(2);

    // Zero-latency memory, back-to-back fetch, plus wrap on the second instance.
    check("w_addr0", w_addr, 32'hFFFF_FFF8);
    check("addr0", addr, 32'h0);
    fetch(1'b1);
    check("seq_pc4_4", ifid_pc4, 32'h4);
    check("seq_instr_0", ifid_instr, 32'hA5A5_A5A5);
    check("w_addr1", w_addr, 32'hFFFF_FFFC);
    fetch(1'b1);
    check("seq_pc4_8", ifid_pc4, 32'h8);
    check("w_addr2", w_addr, 32'h0000_0000);
    fetch(1'b1);
    check("seq_pc4_c", ifid_pc4, 32'hC);
    check("seq_instr_8", ifid_instr, 32'hA5A5_A5AD);
    fetch(1'b1);
    check("seq_pc4_10", ifid_pc4, 32'h10);

    // Redirect target table.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, vecs[i].br, vecs[i].jmp, vecs[i].off, vecs[i].base, vecs[i].idx, 1'b1);
      check("redir_bubble", 32'(ifid_valid), 32'h0);
      check("redir_addr", addr, vecs[i].exp_addr);
      fetch(1'b1);
      check("redir_pc4", ifid_pc4, vecs[i].exp_addr + 32'd4);
      check("redir_instr", ifid_instr, vecs[i].exp_addr ^ PAT);
    end

    // Slow memory: redirect to 0x40 in the first wait cycle, ack arrives 3 cycles late.
    p = m_pc;
    step(1'b0, 1'b1, 1'b0, 16'h0, 32'h40, 26'h0, 1'b0);
    check("slow_addr_w1", addr, p);
    check("slow_bubble_w1", 32'(ifid_valid), 32'h0);
    fetch(1'b0);
    check("slow_addr_w2", addr, p);
    check("slow_bubble_w2", 32'(ifid_valid), 32'h0);
    fetch(1'b0);
    check("slow_addr_w3", addr, p);
    fetch(1'b1);
    check("slow_discard", 32'(ifid_valid), 32'h0);
    check("slow_new_addr", addr, 32'h40);
    fetch(1'b1);
    check("slow_pc4", ifid_pc4, 32'h44);
    check("slow_valid", 32'(ifid_valid), 32'h1);

    // Stall for 4 cycles while an ack arrives; a redirect during stall is ignored.
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 26'h0, 1'b1);
    check("stall_req_low", 32'(req), 32'h0);
    check("stall_pc", pc, 32'h48);
    check("stall_frozen", ifid_pc4, 32'h44);
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 26'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 32'h100, 26'h0, 1'b0);
    check("stall_redir_ignored", pc, 32'h48);
    step(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 26'h0, 1'b0);
    check("stall_frozen4", ifid_pc4, 32'h44);
    check("stall_pc4x", pc, 32'h48);
    fetch(1'b0);
    check("unstall_pc4", ifid_pc4, 32'h48);
    check("unstall_instr", ifid_instr, 32'h44 ^ PAT);
    check("unstall_addr", addr, 32'h48);
    fetch(1'b1);
    check("resume_pc4", ifid_pc4, 32'h4C);

    // Reset while a request is outstanding.
    fetch(1'b0);
    check("midwait_req", 32'(req), 32'h1);
    apply_reset(1);
    check("post_rst_addr", addr, 32'h0);
    check("post_rst_req", 32'(req), 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic s, b, j, a;
      if ($urandom_range(0, 499) == 0) apply_reset(1);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 15);
      j = ($urandom_range(0, 99) < 8);
      a = model_req() ? ($urandom_range(0, 99) < 60) : 1'b0;
      step(s, b, j, 16'($urandom), $urandom & 32'hFFFF_FFFC, 26'($urandom), a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
